// File: rtl/bpu_ghr_index.sv
// Global-history branch index unit: hashes PC with speculative history, tracks in-flight
// branches in a FIFO and emits registered PHT updates as branches resolve in order.
module bpu_ghr_index #(
  parameter int PHT_WIDTH   = 6,
  parameter int GHR_WIDTH   = 6,
  parameter int QUEUE_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         lookup_valid,
  input  logic [31:0]                  lookup_pc,
  output logic [PHT_WIDTH-1:0]         lookup_addr,
  input  logic                         pred_taken,
  output logic                         lookup_ready,
  input  logic                         resolve_valid,
  input  logic                         resolve_taken,
  input  logic                         resolve_mispredict,
  input  logic                         flush,
  output logic                         branch_en,
  output logic [PHT_WIDTH-1:0]         update_addr,
  output logic                         taken,
  output logic [$clog2(QUEUE_DEPTH):0] count
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam logic [PTR_W:0] DEPTH = (PTR_W+1)'(QUEUE_DEPTH);

  logic [GHR_WIDTH-1:0] spec_ghr;
  logic [GHR_WIDTH-1:0] arch_ghr;
  logic [GHR_WIDTH-1:0] arch_next;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PHT_WIDTH-1:0] mem [QUEUE_DEPTH];
  logic                 resolve;
  logic                 kill;
  logic                 accept;
  logic                 unused_pc_bits;

  assign unused_pc_bits = ^{lookup_pc[31:PHT_WIDTH+2], lookup_pc[1:0]};

  assign lookup_addr  = lookup_pc[PHT_WIDTH+1:2] ^ spec_ghr[PHT_WIDTH-1:0];
  assign lookup_ready = (count < DEPTH);
  assign resolve      = resolve_valid && (count != '0);
  assign kill         = resolve && resolve_mispredict;
  // A mispredict squashes everything younger, including a branch arriving this cycle.
  assign accept       = lookup_valid && lookup_ready && !flush && !kill;
  assign arch_next    = resolve ? {arch_ghr[GHR_WIDTH-2:0], resolve_taken} : arch_ghr;

  always_ff @(posedge clk) begin
    if (rst) begin
      spec_ghr    <= '0;
      arch_ghr    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      branch_en   <= 1'b0;
      update_addr <= '0;
      taken       <= 1'b0;
    end else begin
      arch_ghr  <= arch_next;
      branch_en <= resolve;
      if (resolve) begin
        update_addr <= mem[rd_ptr];
        taken       <= resolve_taken;
      end
      // Recovery restarts speculation from the resolved history, including this cycle's outcome.
      if (flush || kill) begin
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        spec_ghr <= arch_next;
      end else begin
        if (accept) begin
          wr_ptr   <= wr_ptr + 1'b1;
          spec_ghr <= {spec_ghr[GHR_WIDTH-2:0], pred_taken};
        end
        if (resolve) rd_ptr <= rd_ptr + 1'b1;
        case ({accept, resolve})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= lookup_addr;
  end

endmodule

// File: doc/bpu_ghr_index.md
BPU_GHR_INDEX -- requirements
Module: bpu_ghr_index

Interface
REQ-001 SHALL have parameter PHT_WIDTH, default 6, giving the width of the pattern-history-table index.
REQ-002 SHALL have parameter GHR_WIDTH, default 6, giving the width of the global history register; GHR_WIDTH >= PHT_WIDTH.
REQ-003 SHALL have parameter QUEUE_DEPTH, default 8, giving the number of in-flight predicted branches, a power of two >= 2.
REQ-004 SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port lookup_valid, input, 1 bit: the fetch stage presents a conditional branch for prediction.
REQ-007 SHALL have port lookup_pc, input, 32 bits: the PC of the presented branch.
REQ-008 SHALL have port lookup_addr, output, PHT_WIDTH bits: the combinational index to the PHT lookup port.
REQ-009 SHALL have port pred_taken, input, 1 bit: the PHT prediction for lookup_addr, valid in the same cycle.
REQ-010 SHALL have port lookup_ready, output, 1 bit: the queue can accept a branch this cycle.
REQ-011 SHALL have port resolve_valid, input, 1 bit: the oldest in-flight branch resolves this cycle.
REQ-012 SHALL have port resolve_taken, input, 1 bit: the actual direction of the resolving branch.
REQ-013 SHALL have port resolve_mispredict, input, 1 bit: the resolving branch was mispredicted.
REQ-014 SHALL have port flush, input, 1 bit: non-branch pipeline flush (exception or ertn) that squashes all in-flight branches.
REQ-015 SHALL have port branch_en, output, 1 bit: registered PHT update strobe.
REQ-016 SHALL have port update_addr, output, PHT_WIDTH bits: registered PHT update index.
REQ-017 SHALL have port taken, output, 1 bit: registered PHT update direction.
REQ-018 SHALL have port count, output, log2(QUEUE_DEPTH)+1 bits: the number of in-flight entries.

Function
REQ-019 SHALL hold spec_ghr (speculative history) and arch_ghr (resolved history), both GHR_WIDTH bits, with bit 0 as the newest outcome.
REQ-020 SHALL drive lookup_addr = lookup_pc[PHT_WIDTH+1:2] XOR spec_ghr[PHT_WIDTH-1:0] combinationally.
REQ-021 SHALL drive lookup_ready = (count < QUEUE_DEPTH); a full queue blocks a push even when a pop occurs in the same cycle.
REQ-022 SHALL define an accept as lookup_valid && lookup_ready && !flush && !(resolve_valid && resolve_mispredict && count != 0).
REQ-023 On accept SHALL push lookup_addr into a circular FIFO (write pointer wraps modulo QUEUE_DEPTH) and set spec_ghr <= {spec_ghr[GHR_WIDTH-2:0], pred_taken}.
REQ-024 SHALL define a resolve as resolve_valid && count != 0; resolve_valid while count == 0 SHALL be ignored, with no update emitted and no state change.
REQ-025 On resolve SHALL pop the oldest entry, set arch_ghr <= {arch_ghr[GHR_WIDTH-2:0], resolve_taken}, and in the next cycle drive branch_en=1, update_addr=popped index and taken=resolve_taken.
REQ-026 When no resolve occurs, branch_en SHALL be 0 in the next cycle, and update_addr/taken SHALL hold their previous values.
REQ-027 A resolve with resolve_mispredict=1 SHALL clear the queue (count=0, pointers equal) and set spec_ghr to the new arch_ghr value.
REQ-028 flush SHALL clear the queue and set spec_ghr to arch_ghr; if a resolve occurs in the same cycle, that resolve SHALL be processed (update emitted, arch_ghr advanced) and spec_ghr SHALL take the new arch_ghr value.
REQ-029 A simultaneous accept and non-mispredict resolve SHALL push and pop together, leaving count unchanged, with spec_ghr shifting on pred_taken.
REQ-030 count SHALL never exceed QUEUE_DEPTH and never underflow.

Reset
REQ-031 While rst=1, SHALL set spec_ghr=0, arch_ghr=0, count=0, both pointers=0, branch_en=0, update_addr=0 and taken=0; rst SHALL override all other inputs.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight entries; no branch_en SHALL appear in the cycle after reset releases.

Verification
REQ-033 After reset, lookup_pc=0x1C with pred_taken=1 -> lookup_addr=7; next cycle spec_ghr=1, and the same PC -> lookup_addr=6.
REQ-034 Eight accepts with no resolve -> count=8 and lookup_ready=0; a ninth lookup_valid -> no push, spec_ghr unchanged.
REQ-035 Single entry index 7, resolve_taken=1, mispredict=0 -> next cycle branch_en=1, update_addr=7, taken=1; arch_ghr=1; count=0.
REQ-036 Three accepts, all pred_taken=1 (spec_ghr=0b000111), then resolve oldest with taken=0, mispredict=1 -> count=0, spec_ghr=arch_ghr=0, and next cycle branch_en=1, taken=0.
REQ-037 Two entries, flush and a non-mispredict resolve taken=1 in the same cycle -> one update emitted, count=0, spec_ghr=arch_ghr=1.
REQ-038 Empty queue with resolve_valid=1 -> branch_en stays 0 and arch_ghr is unchanged.
